// File: rtl/calc_io_pkg.sv
// Shared constants for the calculator IO path: button bit order as seen by
// the IO block, default conditioning timings and a counter-width helper.
// Optional build feature: BTN_AUTO_REPEAT_EN (auto-repeat while held).
package calc_io_pkg;

  // Button bit positions, matching the IO block's button input port
  localparam int BTN_EQ  = 0;
  localparam int BTN_MUL = 1;
  localparam int BTN_SUB = 2;
  localparam int BTN_ADD = 3;

  localparam int N_BTN_DEFAULT           = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 20;
  localparam int REPEAT_CYCLES_DEFAULT   = 500;

  // Bits needed to hold values 0..max_count (never less than one bit)
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: two-flop synchroniser, counter debouncer, rising-edge pulse
// and sticky press flag cleared by ack. With BTN_AUTO_REPEAT_EN defined, a
// held button re-pulses every REPEAT_CYCLES cycles after the initial press.
module btn_debounce_bit
  import calc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BTN_AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic ack,
  output logic level,
  output logic pulse,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          level_d;
  logic          rise;
  logic          fire;

  // Two-flop synchroniser for the asynchronous raw level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles;
  // any return to the stable value restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered debounced level plus its one-cycle-delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level   <= stable;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_hit;

  assign rep_hit = level & (rep_cnt == REP_LAST);

  // Cycles since the last pulse while held; cleared on release or re-pulse
  always_ff @(posedge clk) begin
    if (reset || !level) begin
      rep_cnt <= '0;
    end else if (rise || rep_hit) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign fire = rise | rep_hit;
`else
  assign fire = rise;
`endif

  // One-cycle pulse and sticky flag; a pulse visible in the ack cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 1'b0;
      press <= 1'b0;
    end else begin
      pulse <= fire;
      press <= fire | pulse | (press & ~ack);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw push-buttons (add, sub, multiply, =) for the IO block:
// one independent btn_debounce_bit per button, all on the CPU clock.
// Optional build feature: BTN_AUTO_REPEAT_EN (auto-repeat while held).
module btn_conditioner
  import calc_io_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] ack,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .ack  (ack[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i]),
      .press(btn_press[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw push-buttons before they reach the memory-mapped IO block's button input port (add, sub, multiply, =).
- Per button: two-flop synchroniser, counter debouncer, rising-edge detector, and a sticky "pressed" flag.
- Firmware polls at the slow CPU clock and cannot miss a short press. Firmware clears each flag by writing an acknowledge bit.
- Sits between the board buttons and the IO block. Runs on the CPU clock domain.

Parameters:
- N_BTN, 4, number of buttons conditioned in parallel.
- DEBOUNCE_CYCLES, 20, consecutive clk cycles a new synchronised level must hold before it is accepted. Must be >= 1.
- REPEAT_CYCLES, 500, auto-repeat interval in clk cycles. Used only when the optional feature is compiled in.

Ports:
- clk  input  1  CPU clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  asynchronous raw button levels, active-high.
- ack  input  N_BTN  per-button clear of btn_press. One-cycle pulse from the IO write decode.
- btn_level  output  N_BTN  debounced stable level.
- btn_pulse  output  N_BTN  one-cycle pulse on each accepted press.
- btn_press  output  N_BTN  sticky press flag, held until acknowledged.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset, at the clk edge with reset=1:
  - sync flops, stable levels, counters, btn_level, btn_pulse and btn_press all go to 0.
  - reset overrides every other event, including a press in progress.
- Synchroniser: s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
- Debounce, independently per bit:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == stable, the counter goes to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, then stable <= s2 and the counter goes to 0. Otherwise the counter increments.
  - Any bounce back to the stable value before acceptance restarts the count from 0.
- Latency: a clean raw edge appears on btn_level exactly 2 + DEBOUNCE_CYCLES cycles after the first sampling edge.
- btn_level = stable, registered.
- btn_pulse: asserted for exactly one cycle, the cycle after stable rises 0->1. Never asserted on release.
- btn_press:
  - Set when btn_pulse is 1.
  - Cleared when ack is 1 and btn_pulse is 0.
  - If btn_pulse and ack occur in the same cycle, set wins and the flag stays 1.
  - ack on an already-clear flag has no effect.
- Buttons are fully independent. Simultaneous presses set multiple flags in the same cycle.
- No counter wraps: the counter is bounded by DEBOUNCE_CYCLES-1 and the repeat counter by REPEAT_CYCLES-1.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- With the macro defined:
  - While btn_level stays 1, a per-button repeat counter counts clk cycles from the accepted press.
  - Every REPEAT_CYCLES cycles it generates another btn_pulse and sets btn_press.
  - The repeat counter clears when btn_level falls and on reset.
  - The first repeat comes REPEAT_CYCLES cycles after the initial pulse.
- Without the macro: no repeat logic is instantiated, and exactly one pulse is produced per press regardless of hold time.

Decomposition:
- Shared package (calc_io_pkg):
  - Button index constants: BTN_EQ=0, BTN_MUL=1, BTN_SUB=2, BTN_ADD=3. These match the IO block's button bit order.
  - Default DEBOUNCE_CYCLES and REPEAT_CYCLES.
- One sub-module, btn_debounce_bit: a single-bit synchroniser, debouncer, edge detector and sticky flag. The top instantiates it in a generate loop over N_BTN.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10, N_BTN=4):
- Reset: drive btn_raw=4'b1111, reset=1 for 3 cycles -> all outputs 0 throughout. After release, btn_level=4'b1111 exactly 6 cycles later, and btn_press=4'b1111.
- Clean press: btn_raw[0] rises and stays high -> btn_level[0]=1 at cycle 6. btn_pulse[0] is high only at cycle 7. btn_press[0] is 1 from cycle 7 until ack[0]; it is 0 the cycle after ack.
- Bounce: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no btn_pulse during bouncing. A single btn_pulse[1] occurs 7 cycles after the final rise.
- Ack collision: assert ack[2] in the same cycle as btn_pulse[2] -> btn_press[2] remains 1. A later ack[2] clears it.
- Glitch rejection: a 3-cycle high on btn_raw[3] -> btn_level, btn_pulse and btn_press stay 0.
- BTN_AUTO_REPEAT_EN: hold btn_raw[0] for 40 cycles after acceptance -> btn_pulse[0] at +0, +10, +20, +30. After release, no further pulses. Without the macro, exactly one pulse.
